// File: rtl/calc2_quad_alu.sv
// calc2_quad_alu: four independent tagged two-cycle add/sub/shift channels with registered responses
module calc2_quad_alu #(
  parameter int DATA_W = 32,
  parameter int CMD_W = 4,
  parameter int TAG_W = 2
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  req1_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [TAG_W-1:0]  req1_tag_in,
  input  logic [CMD_W-1:0]  req2_cmd_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [TAG_W-1:0]  req2_tag_in,
  input  logic [CMD_W-1:0]  req3_cmd_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [TAG_W-1:0]  req3_tag_in,
  input  logic [CMD_W-1:0]  req4_cmd_in,
  input  logic [DATA_W-1:0] req4_data_in,
  input  logic [TAG_W-1:0]  req4_tag_in,
  output logic [1:0]        out_resp1,
  output logic [DATA_W-1:0] out_data1,
  output logic [TAG_W-1:0]  out_tag1,
  output logic [1:0]        out_resp2,
  output logic [DATA_W-1:0] out_data2,
  output logic [TAG_W-1:0]  out_tag2,
  output logic [1:0]        out_resp3,
  output logic [DATA_W-1:0] out_data3,
  output logic [TAG_W-1:0]  out_tag3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data4,
  output logic [TAG_W-1:0]  out_tag4
);
  typedef enum logic [1:0] {IDLE, OP2, EXEC} state_t;
  localparam logic [CMD_W-1:0] ADD = CMD_W'(1);
  localparam logic [CMD_W-1:0] SUB = CMD_W'(2);
  localparam logic [CMD_W-1:0] SHL = CMD_W'(5);
  localparam logic [CMD_W-1:0] SHR = CMD_W'(6);
  logic [CMD_W-1:0]  cmd  [4];
  logic [DATA_W-1:0] din  [4];
  logic [TAG_W-1:0]  tin  [4];
  logic [1:0]        resp [4];
  logic [DATA_W-1:0] dout [4];
  logic [TAG_W-1:0]  tout [4];
  assign cmd[0] = req1_cmd_in;
  assign cmd[1] = req2_cmd_in;
  assign cmd[2] = req3_cmd_in;
  assign cmd[3] = req4_cmd_in;
  assign din[0] = req1_data_in;
  assign din[1] = req2_data_in;
  assign din[2] = req3_data_in;
  assign din[3] = req4_data_in;
  assign tin[0] = req1_tag_in;
  assign tin[1] = req2_tag_in;
  assign tin[2] = req3_tag_in;
  assign tin[3] = req4_tag_in;
  assign out_resp1 = resp[0];
  assign out_resp2 = resp[1];
  assign out_resp3 = resp[2];
  assign out_resp4 = resp[3];
  assign out_data1 = dout[0];
  assign out_data2 = dout[1];
  assign out_data3 = dout[2];
  assign out_data4 = dout[3];
  assign out_tag1 = tout[0];
  assign out_tag2 = tout[1];
  assign out_tag3 = tout[2];
  assign out_tag4 = tout[3];
  for (genvar i = 0; i < 4; i++) begin : g_ch
    state_t state, state_nx;
    logic [CMD_W-1:0]  cmd_q;
    logic [TAG_W-1:0]  tag_q, tag_out;
    logic [DATA_W-1:0] op1, op2, res_val, res_data, data_out;
    logic [DATA_W:0]   sum;
    logic [1:0]        res_resp, resp_out;
    logic              res_ok;
    always_ff @(posedge c_clk) state <= reset ? IDLE : state_nx;
    // EXEC accepts a new command directly, giving one response every two cycles
    always_comb state_nx = state == OP2 ? EXEC : cmd[i] != '0 ? OP2 : IDLE;
    assign sum = {1'b0, op1} + {1'b0, op2};
    always_comb begin
      res_ok = cmd_q == ADD ? !sum[DATA_W] : cmd_q == SUB ? op1 >= op2 : cmd_q == SHL || cmd_q == SHR;
      res_val = cmd_q == ADD ? sum[DATA_W-1:0] : cmd_q == SUB ? op1 - op2 :
                cmd_q == SHL ? op1 << op2[4:0] : op1 >> op2[4:0];
      res_resp = res_ok ? 2'd1 : 2'd2;
      res_data = res_ok ? res_val : '0;
    end
    always_ff @(posedge c_clk) begin
      if (reset) begin
        cmd_q <= '0;
        tag_q <= '0;
        op1 <= '0;
        op2 <= '0;
        resp_out <= '0;
        data_out <= '0;
        tag_out <= '0;
      end else begin
        if (state != OP2 && cmd[i] != '0) begin
          cmd_q <= cmd[i];
          tag_q <= tin[i];
          op1 <= din[i];
        end
        if (state == OP2) op2 <= din[i];
        resp_out <= state == EXEC ? res_resp : 2'd0;
        data_out <= state == EXEC ? res_data : '0;
        tag_out <= state == EXEC ? tag_q : '0;
      end
    end
    assign resp[i] = resp_out;
    assign dout[i] = data_out;
    assign tout[i] = tag_out;
  end
endmodule

// File: tb/tb_calc2_quad_alu.sv
// tb_calc2_quad_alu: scoreboard bench; drivers push expected responses, a monitor checks every cycle
module tb_calc2_quad_alu;
  logic c_clk = 0;
  logic reset = 1;
  logic [3:0]  cmd  [4];
  logic [31:0] din  [4];
  logic [1:0]  tin  [4];
  logic [1:0]  resp [4];
  logic [31:0] dout [4];
  logic [1:0]  tout [4];
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  bit done = 0;
  typedef struct {int due; logic [1:0] r; logic [31:0] d; logic [1:0] t;} exp_t;
  exp_t q [4][$];

  calc2_quad_alu dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(cmd[0]), .req1_data_in(din[0]), .req1_tag_in(tin[0]),
    .req2_cmd_in(cmd[1]), .req2_data_in(din[1]), .req2_tag_in(tin[1]),
    .req3_cmd_in(cmd[2]), .req3_data_in(din[2]), .req3_tag_in(tin[2]),
    .req4_cmd_in(cmd[3]), .req4_data_in(din[3]), .req4_tag_in(tin[3]),
    .out_resp1(resp[0]), .out_data1(dout[0]), .out_tag1(tout[0]),
    .out_resp2(resp[1]), .out_data2(dout[1]), .out_tag2(tout[1]),
    .out_resp3(resp[2]), .out_data3(dout[2]), .out_tag3(tout[2]),
    .out_resp4(resp[3]), .out_data4(dout[3]), .out_tag4(tout[3])
  );

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint unsigned s;
    s = longint'(a) + longint'(b);
    case (c)
      4'd1: return s > 64'hFFFF_FFFF ? {2'd2, 32'd0} : {2'd1, a + b};
      4'd2: return b > a ? {2'd2, 32'd0} : {2'd1, a - b};
      4'd5: return {2'd1, a << (b % 32)};
      4'd6: return {2'd1, a >> (b % 32)};
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  task automatic issue(input int p, input logic [3:0] c, input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    logic [33:0] m;
    m = model(c, a, b);
    cmd[p] = c;
    tin[p] = t;
    din[p] = a;
    if (c != 0) q[p].push_back('{cyc + 3, m[33:32], m[31:0], t});
    @(posedge c_clk); #1;
    din[p] = b;
    cmd[p] = 4'($urandom);
    tin[p] = 2'($urandom);
    @(posedge c_clk); #1;
    cmd[p] = 0;
    din[p] = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge c_clk);
    #1;
  endtask

  task automatic rand_port(input int p, input int n);
    logic [3:0] c;
    logic [31:0] a, b;
    for (int k = 0; k < n; k++) begin
      c = $urandom_range(0, 9) < 8 ? 4'(3'($urandom_range(0, 3)) == 0 ? 1 : $urandom_range(0, 2) == 0 ? 2 : $urandom_range(0, 1) ? 5 : 6) : 4'($urandom_range(3, 15));
      a = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
      b = $urandom_range(0, 3) == 0 ? $urandom_range(0, 40) : $urandom;
      issue(p, c, 2'($urandom), a, b);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end
  endtask

  always @(negedge c_clk) begin
    if (cyc >= 1 && !done) begin
      for (int p = 0; p < 4; p++) begin
        exp_t e;
        e = '{0, 2'd0, 32'd0, 2'd0};
        if (q[p].size() > 0 && q[p][0].due == cyc) e = q[p].pop_front();
        checks++;
        if (resp[p] === e.r && dout[p] === e.d && tout[p] === e.t) passed++;
        else $display("FAIL port%0d cyc%0d: got resp=%0d data=%h tag=%0d, want resp=%0d data=%h tag=%0d",
                      p + 1, cyc, resp[p], dout[p], tout[p], e.r, e.d, e.t);
      end
    end
  end

  initial begin
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 0;
      din[p] = 0;
      tin[p] = 0;
    end
    reset = 1;
    idle(2);
    reset = 0;
    idle(3);
    fork
      issue(0, 1, 0, 32'h56, 32'h103);
      issue(1, 1, 1, 32'h56, 32'h103);
      issue(2, 1, 2, 32'h56, 32'h103);
      issue(3, 1, 3, 32'h56, 32'h103);
    join
    idle(2);
    fork
      issue(0, 2, 3, 32'h158, 32'h12);
      issue(1, 2, 2, 32'h158, 32'h12);
      issue(2, 2, 1, 32'h158, 32'h12);
      issue(3, 2, 0, 32'h158, 32'h12);
    join
    idle(2);
    issue(0, 2, 1, 32'h12, 32'h158);
    issue(0, 2, 2, 32'h5, 32'h5);
    issue(0, 1, 3, 32'hFFFF_FFFF, 32'h1);
    issue(0, 1, 0, 32'hFFFF_FFFE, 32'h1);
    issue(0, 5, 1, 32'h1, 32'h4);
    issue(0, 5, 2, 32'h1, 32'h21);
    issue(0, 6, 3, 32'h8000_0000, 32'd31);
    issue(0, 6, 0, 32'hF, 32'h0);
    issue(0, 3, 2, 32'h1234, 32'h5678);
    idle(2);
    issue(1, 1, 1, 32'h10, 32'h20);
    issue(1, 2, 2, 32'h30, 32'h8);
    idle(2);
    cmd[0] = 1;
    tin[0] = 1;
    din[0] = 32'h7;
    @(posedge c_clk); #1;
    din[0] = 32'h9;
    cmd[0] = 0;
    reset = 1;
    @(posedge c_clk); #1;
    reset = 0;
    issue(0, 1, 3, 32'h100, 32'h1);
    idle(3);
    fork
      rand_port(0, 60);
      rand_port(1, 60);
      rand_port(2, 60);
      rand_port(3, 60);
    join
    idle(4);
    done = 1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (q[p].size() == 0) passed++;
      else $display("FAIL port%0d pending: %0d responses never seen, want 0", p + 1, q[p].size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/calc2_quad_alu.md
Name: calc2_quad_alu

Overview:
- Four-port integer calculator; each port carries an independent request/response stream.
- Each port accepts a tagged two-cycle operation: command plus operand 1, then operand 2.
- Each port returns a tagged response code and a 32-bit result.
- Sits between the request agents and a response monitor; the ports share only the clock and reset.

Parameters:
- DATA_W, 32, operand and result width
- CMD_W, 4, command field width
- TAG_W, 2, tag field width

Ports:
- c_clk  input  1  system clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- reqN_cmd_in  input  CMD_W  port N command (N=1..4): 0 no-op, 1 add, 2 sub, 5 shift left, 6 shift right
- reqN_data_in  input  DATA_W  port N operand 1 in the command cycle, operand 2 in the next cycle
- reqN_tag_in  input  TAG_W  port N tag, sampled in the command cycle
- out_respN  output  2  port N response: 0 none, 1 success, 2 overflow/underflow/invalid command, 3 reserved (never driven)
- out_dataN  output  DATA_W  port N result; 0 whenever out_respN is not 1
- out_tagN  output  TAG_W  port N echoed tag; 0 when out_respN is 0

Behaviour:
- Four identical, fully independent port channels. No arbitration; all four may complete in the same cycle.
- Per-port FSM states:
  - IDLE: at an edge where cmd!=0, latch cmd, tag and data as operand 1, go to OP2.
  - OP2: at the next edge, latch data as operand 2 and go to EXEC. Cmd and tag inputs are ignored in this cycle.
  - EXEC: compute and register outputs at the next edge, return to IDLE.
- Timing, with the command sampled at edge k:
  - Operand 2 is sampled at edge k+1.
  - Response registers load at edge k+2 and are valid for exactly one cycle (k+2 to k+3).
  - At edge k+3 the outputs return to 0 unless another response loads.
- Back-to-back: a new command may be presented in the cycle after operand 2, i.e. sampled in EXEC at edge k+2.
  - Its response then loads at edge k+4, giving one response every 2 cycles at maximum rate.
  - So the FSM goes EXEC to OP2 directly when cmd!=0.
- Add: 33-bit sum of op1 and op2.
  - Carry out of bit 31: resp=2, data=0.
  - Otherwise resp=1, data=sum[31:0].
- Sub: if op2 > op1 (unsigned): resp=2, data=0. Otherwise resp=1, data=op1-op2; equal operands give 0 with resp=1.
- Shift left / right: logical, amount = op2[4:0], upper bits of op2 ignored.
  - Zero-fill.
  - Always resp=1; bits shifted out are discarded and are not an overflow.
- Invalid commands (3, 4, 7-15):
  - Still consume the operand-2 cycle.
  - Respond at edge k+2 with resp=2, data=0 and the tag echoed.
- Tag: echoed unchanged with every nonzero response. Tags need not be unique; there is no outstanding-tag tracking.
- Reset:
  - Synchronous. At an edge with reset=1, all out_* are set to 0, all FSMs go to IDLE and all latched operands are cleared.
  - Inputs are ignored while reset=1.
  - Reset during OP2 or EXEC discards the operation; no response is produced for it.
  - A command may be presented in the first cycle after reset deasserts.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset held 2 cycles, then released -> all out_respN, out_dataN and out_tagN are 0; no spurious responses.
- All four ports, add 0x56 + 0x103, tags 0,1,2,3, same cycle -> all four report resp=1, data=0x159 at edge k+2, each with its own tag; outputs are 0 at k+3.
- All four ports, sub 0x158 - 0x12 -> resp=1, data=0x146.
- Boundary cases on port 1:
  - 0x12 - 0x158 -> resp=2, data=0.
  - 0x5 - 0x5 -> resp=1, data=0.
  - 0xFFFFFFFF + 0x1 -> resp=2, data=0.
  - 0xFFFFFFFE + 0x1 -> resp=1, data=0xFFFFFFFF.
- Shifts:
  - shl 0x1 by 0x4 -> 0x10.
  - shl 0x1 by 0x21 -> 0x2 (only op2[4:0] used).
  - shr 0x80000000 by 31 -> 0x1.
  - shr 0xF by 0 -> 0xF.
  - All with resp=1.
- Control cases:
  - Invalid command 3 with tag 2 -> resp=2, data=0, tag=2 at k+2.
  - Back-to-back add then sub on port 2 -> responses at k+2 and k+4 in order.
  - Reset asserted in OP2 -> no response; the next command completes normally.
